// File: rtl/babbage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : babbage_pkg
// Description : Shared FSM encoding and default widths for the babbage blocks
// Revision    : 1.0
// ============================================================================
package babbage_pkg;
    localparam int DEFAULT_I_W = 4;
    localparam int DEFAULT_F_W = 4;

    typedef logic [1:0] state_t;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;
endpackage
`default_nettype wire

// File: rtl/babbage_sweep_if.sv
`default_nettype none
// ============================================================================
// Module      : babbage_sweep_if
// Description : Request/completion handshake between the sweeper and engine
// Revision    : 1.0
// ============================================================================
interface babbage_sweep_if
    import babbage_pkg::*;
#(
    parameter int I_W = DEFAULT_I_W,
    parameter int F_W = DEFAULT_F_W
);
    logic           start;
    logic [I_W-1:0] i;
    logic           done_tick;
    logic [F_W-1:0] f;

    modport master (output start, output i, input  done_tick, input  f);
    modport slave  (input  start, input  i, output done_tick, output f);
endinterface
`default_nettype wire

// File: rtl/babbage_result_ram.sv
`default_nettype none
// ============================================================================
// Module      : babbage_result_ram
// Description : 2^AW x DW result store, synchronous write, asynchronous read
// Revision    : 1.0
// ============================================================================
module babbage_result_ram
    import babbage_pkg::*;
#(
    parameter int AW = DEFAULT_I_W,
    parameter int DW = DEFAULT_F_W
) (
    input  wire logic          clk,
    input  wire logic          we,
    input  wire logic [AW-1:0] wr_addr,
    input  wire logic [DW-1:0] wr_data,
    input  wire logic [AW-1:0] rd_addr,
    output logic      [DW-1:0] rd_data
);
    // Deliberately not reset: contents survive reset and partial sweeps.
    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];
endmodule
`default_nettype wire

// File: rtl/babbage_sweep.sv
`default_nettype none
// ============================================================================
// Module      : babbage_sweep
// Description : Walks the engine index 0..n_last, stores results, flags stalls
// Revision    : 1.0
// ============================================================================
module babbage_sweep
    import babbage_pkg::*;
#(
    parameter int I_W     = DEFAULT_I_W,
    parameter int F_W     = DEFAULT_F_W,
    parameter int TIMEOUT = 1023
) (
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire logic           go,
    input  wire logic [I_W-1:0] n_last,
    babbage_sweep_if.master     eng,
    output logic                busy,
    output logic                sweep_done_tick,
    output logic                err,
    input  wire logic [I_W-1:0] rd_addr,
    output logic      [F_W-1:0] rd_data
);
    localparam int             c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    state_t             r_state;
    logic [I_W-1:0]     r_i;
    logic [I_W-1:0]     r_last;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;
    logic               w_wr_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_i     <= '0;
            r_last  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (go) begin
                        r_last  <= n_last;
                        r_i     <= '0;
                        r_err   <= 1'b0;
                        r_state <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    // Completion is checked first so a late done_tick beats expiry;
                    // comparing before incrementing keeps r_i from wrapping.
                    if (eng.done_tick) begin
                        if (r_i == r_last) begin
                            r_state <= c_DONE;
                        end else begin
                            r_i     <= r_i + 1'b1;
                            r_state <= c_ISSUE;
                        end
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign w_wr_en         = (r_state == c_WAIT) && eng.done_tick;
    assign eng.start       = (r_state == c_ISSUE);
    assign eng.i           = r_i;
    assign busy            = (r_state != c_IDLE);
    assign sweep_done_tick = (r_state == c_DONE);
    assign err             = r_err;

    babbage_result_ram #(
        .AW (I_W),
        .DW (F_W)
    ) u_ram (
        .clk     (clk),
        .we      (w_wr_en),
        .wr_addr (r_i),
        .wr_data (eng.f),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );
endmodule
`default_nettype wire

// File: tb/tb_babbage_sweep.sv
`default_nettype none
// ============================================================================
// Module      : tb_babbage_sweep
// Description : Scoreboard bench for babbage_sweep with a behavioural engine
// Revision    : 1.0
// ============================================================================
module tb_babbage_sweep;
    localparam int I_W     = 4;
    localparam int F_W     = 4;
    localparam int TIMEOUT = 15;

    logic           clk = 1'b0;
    logic           reset;
    logic           go;
    logic [I_W-1:0] n_last;
    logic [I_W-1:0] rd_addr;
    logic           busy;
    logic           sweep_done_tick;
    logic           err;
    logic [F_W-1:0] rd_data;

    babbage_sweep_if #(.I_W(I_W), .F_W(F_W)) eng ();

    babbage_sweep #(.I_W(I_W), .F_W(F_W), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .reset           (reset),
        .go              (go),
        .n_last          (n_last),
        .eng             (eng),
        .busy            (busy),
        .sweep_done_tick (sweep_done_tick),
        .err             (err),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [F_W-1:0] model_f(input int n);
        return F_W'((2 * n * n + 3 * n + 5) % 16);
    endfunction

    // Engine model: answers n+2 cycles after start (or fixed_delay), can stay silent
    int silent_idx  = -1;
    int fixed_delay = -1;
    bit spur_req    = 1'b0;
    int e_cd        = 0;
    int e_idx       = 0;

    initial begin
        eng.done_tick = 1'b0;
        eng.f         = '0;
        forever begin
            @(posedge clk);
            #1;
            eng.done_tick = 1'b0;
            if (e_cd > 0) begin
                e_cd--;
                if (e_cd == 0) begin
                    eng.done_tick = 1'b1;
                    eng.f         = model_f(e_idx);
                end
            end
            if (spur_req) begin
                eng.done_tick = 1'b1;
                eng.f         = 4'hF;
            end
            if (eng.start) begin
                e_idx = int'(eng.i);
                if (e_idx == silent_idx) e_cd = 0;
                else e_cd = (fixed_delay >= 0) ? fixed_delay : e_idx + 2;
            end
        end
    end

    int exp_q[$];
    int obs_i[$];
    int obs_cyc[$];
    int done_at;
    int n_done;
    int go_cyc;

    task automatic pulse_go(input int nl);
        @(negedge clk);
        go     = 1'b1;
        n_last = I_W'(nl);
        go_cyc = cyc;
        @(negedge clk);
        go     = 1'b0;
    endtask

    task automatic capture(input int budget, input int tail);
        int n     = 0;
        int after = -1;
        obs_i.delete();
        obs_cyc.delete();
        done_at = -1;
        n_done  = 0;
        while (n < budget && (after < 0 || n < after + tail)) begin
            if (eng.start) begin
                obs_i.push_back(int'(eng.i));
                obs_cyc.push_back(cyc);
            end
            if (sweep_done_tick) begin
                n_done++;
                if (done_at < 0) begin
                    done_at = cyc;
                    after   = n;
                end
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; go = 1'b0; n_last = '0; rd_addr = '0;
        repeat (2) @(negedge clk);
        checks += 5;
        if (eng.start !== 1'b0)      begin errors++; $display("FAIL reset_start: got %b expected 0", eng.start); end
        if (eng.i !== 4'd0)          begin errors++; $display("FAIL reset_i: got %0d expected 0", eng.i); end
        if (busy !== 1'b0)           begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (sweep_done_tick !== 1'b0) begin errors++; $display("FAIL reset_sdt: got %b expected 0", sweep_done_tick); end
        if (err !== 1'b0)            begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sweep3();
        for (int k = 0; k <= 3; k++) exp_q.push_back(k);
        pulse_go(3);
        capture(300, 4);
        checks += 4;
        if (obs_i.size() != 4) begin errors++; $display("FAIL sweep3_starts: got %0d expected 4", obs_i.size()); end
        if (done_at < 0)       begin errors++; $display("FAIL sweep3_done_seen: got none expected 1"); end
        if (n_done != 1)       begin errors++; $display("FAIL sweep3_done_count: got %0d expected 1", n_done); end
        if (err !== 1'b0)      begin errors++; $display("FAIL sweep3_err: got %b expected 0", err); end
        if (obs_cyc.size() == 4) begin
            checks += 2;
            if (obs_cyc[0] != go_cyc + 1) begin errors++; $display("FAIL sweep3_first_lat: got %0d expected 1", obs_cyc[0] - go_cyc); end
            if (done_at != obs_cyc[3] + 6) begin errors++; $display("FAIL sweep3_done_lat: got %0d expected 6", done_at - obs_cyc[3]); end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_cyc[k+1] - obs_cyc[k] != k + 3) begin
                    errors++; $display("FAIL sweep3_period[%0d]: got %0d expected %0d", k, obs_cyc[k+1] - obs_cyc[k], k + 3);
                end
            end
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            int e = exp_q.pop_front();
            checks++;
            if (k >= obs_i.size() || obs_i[k] != e) begin
                errors++; $display("FAIL sweep3_i[%0d]: got %0d expected %0d", k, (k < obs_i.size()) ? obs_i[k] : -1, e);
            end
        end
        for (int a = 0; a < 4; a++) begin
            rd_addr = I_W'(a); #1;
            checks++;
            if (rd_data !== model_f(a)) begin errors++; $display("FAIL sweep3_mem[%0d]: got %0d expected %0d", a, rd_data, model_f(a)); end
        end
    endtask

    task automatic test_single();
        exp_q.push_back(0);
        pulse_go(0);
        capture(100, 4);
        checks += 3;
        if (obs_i.size() != 1) begin errors++; $display("FAIL single_starts: got %0d expected 1", obs_i.size()); end
        if (obs_cyc.size() >= 1 && done_at != obs_cyc[0] + 3) begin
            errors++; $display("FAIL single_done_lat: got %0d expected 3", done_at - obs_cyc[0]);
        end
        if (n_done != 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", n_done); end
        while (exp_q.size() > 0) begin
            int e = exp_q.pop_front();
            checks++;
            if (obs_i.size() < 1 || obs_i[0] != e) begin errors++; $display("FAIL single_i: got %0d expected %0d", (obs_i.size() > 0) ? obs_i[0] : -1, e); end
        end
        rd_addr = '0; #1;
        checks++;
        if (rd_data !== 4'd5) begin errors++; $display("FAIL single_mem0: got %0d expected 5", rd_data); end
    endtask

    task automatic test_timeout();
        silent_idx = 2;
        for (int k = 0; k <= 2; k++) exp_q.push_back(k);
        pulse_go(5);
        capture(300, 6);
        silent_idx = -1;
        checks += 3;
        if (obs_i.size() != 3) begin errors++; $display("FAIL timeout_starts: got %0d expected 3", obs_i.size()); end
        if (obs_cyc.size() >= 3 && done_at != obs_cyc[2] + 16) begin
            errors++; $display("FAIL timeout_done_lat: got %0d expected 16", done_at - obs_cyc[2]);
        end
        if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", err); end
        for (int k = 0; exp_q.size() > 0; k++) begin
            int e = exp_q.pop_front();
            checks++;
            if (k >= obs_i.size() || obs_i[k] != e) begin
                errors++; $display("FAIL timeout_i[%0d]: got %0d expected %0d", k, (k < obs_i.size()) ? obs_i[k] : -1, e);
            end
        end
        rd_addr = 4'd2; #1;
        checks++;
        if (rd_data !== 4'd3) begin errors++; $display("FAIL timeout_mem2_kept: got %0d expected 3", rd_data); end
        rd_addr = 4'd3; #1;
        checks++;
        if (rd_data !== 4'd0) begin errors++; $display("FAIL timeout_mem3_kept: got %0d expected 0", rd_data); end
    endtask

    task automatic test_edge_timeout();
        fixed_delay = TIMEOUT;
        exp_q.push_back(0);
        exp_q.push_back(1);
        pulse_go(1);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL edge_err_cleared: got %b expected 0", err); end
        capture(300, 4);
        fixed_delay = -1;
        checks += 3;
        if (obs_i.size() != 2) begin errors++; $display("FAIL edge_starts: got %0d expected 2", obs_i.size()); end
        if (err !== 1'b0)      begin errors++; $display("FAIL edge_err: got %b expected 0", err); end
        if (obs_cyc.size() == 2 && (obs_cyc[1] - obs_cyc[0] != 16 || done_at != obs_cyc[1] + 16)) begin
            errors++; $display("FAIL edge_timing: got %0d/%0d expected 16/16", obs_cyc[1] - obs_cyc[0], done_at - obs_cyc[1]);
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            int e = exp_q.pop_front();
            checks++;
            if (k >= obs_i.size() || obs_i[k] != e) begin
                errors++; $display("FAIL edge_i[%0d]: got %0d expected %0d", k, (k < obs_i.size()) ? obs_i[k] : -1, e);
            end
        end
        rd_addr = 4'd1; #1;
        checks++;
        if (rd_data !== 4'd10) begin errors++; $display("FAIL edge_mem1: got %0d expected 10", rd_data); end
    endtask

    task automatic test_go_ignored();
        for (int k = 0; k <= 3; k++) exp_q.push_back(k);
        pulse_go(3);
        fork
            capture(300, 4);
            begin
                repeat (4) @(negedge clk);
                go = 1'b1; n_last = 4'd7;
                @(negedge clk);
                go = 1'b0;
            end
        join
        checks++;
        if (obs_i.size() != 4) begin errors++; $display("FAIL goign_starts: got %0d expected 4", obs_i.size()); end
        for (int k = 0; exp_q.size() > 0; k++) begin
            int e = exp_q.pop_front();
            checks++;
            if (k >= obs_i.size() || obs_i[k] != e) begin
                errors++; $display("FAIL goign_i[%0d]: got %0d expected %0d", k, (k < obs_i.size()) ? obs_i[k] : -1, e);
            end
        end
        // Spurious completion while idle; i still points at 3
        repeat (2) @(negedge clk);
        spur_req = 1'b1;
        @(negedge clk);
        spur_req = 1'b0;
        repeat (2) @(negedge clk);
        rd_addr = 4'd3; #1;
        checks += 2;
        if (rd_data !== 4'd0) begin errors++; $display("FAIL spur_mem3: got %0d expected 0", rd_data); end
        if (busy !== 1'b0)    begin errors++; $display("FAIL spur_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int  n           = 0;
        bit  found       = 1'b0;
        int  starts_after = 0;
        for (int k = 0; k <= 5; k++) exp_q.push_back(k);
        obs_i.delete();
        pulse_go(15);
        while (n < 400 && !found) begin
            if (eng.start) begin
                obs_i.push_back(int'(eng.i));
                if (int'(eng.i) == 5) found = 1'b1;
            end
            if (!found) begin @(negedge clk); n++; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rmid_reach_i5: got none expected start with i=5"); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks += 5;
        if (eng.start !== 1'b0)       begin errors++; $display("FAIL rmid_start: got %b expected 0", eng.start); end
        if (eng.i !== 4'd0)           begin errors++; $display("FAIL rmid_i: got %0d expected 0", eng.i); end
        if (busy !== 1'b0)            begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        if (sweep_done_tick !== 1'b0) begin errors++; $display("FAIL rmid_sdt: got %b expected 0", sweep_done_tick); end
        if (err !== 1'b0)             begin errors++; $display("FAIL rmid_err: got %b expected 0", err); end
        reset = 1'b0;
        for (int k = 0; exp_q.size() > 0; k++) begin
            int e = exp_q.pop_front();
            checks++;
            if (k >= obs_i.size() || obs_i[k] != e) begin
                errors++; $display("FAIL rmid_i[%0d]: got %0d expected %0d", k, (k < obs_i.size()) ? obs_i[k] : -1, e);
            end
        end
        repeat (30) begin
            @(negedge clk);
            if (eng.start) starts_after++;
        end
        checks++;
        if (starts_after != 0) begin errors++; $display("FAIL rmid_no_start: got %0d expected 0", starts_after); end
        for (int a = 0; a <= 4; a++) begin
            rd_addr = I_W'(a); #1;
            checks++;
            if (rd_data !== model_f(a)) begin errors++; $display("FAIL rmid_mem[%0d]: got %0d expected %0d", a, rd_data, model_f(a)); end
        end
    endtask

    initial begin
        test_reset();
        test_sweep3();
        test_single();
        test_timeout();
        test_edge_timeout();
        test_go_ignored();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/babbage_sweep.md
# babbage_sweep

Initiator-side controller for the `babbage` difference engine: on a single `go` pulse it walks `i` from 0 up to a programmed last index and issues one `start` per value. It waits for each `done_tick`, captures `f` into a small result memory, and flags a stalled engine with a timeout. It sits between the board switches/buttons and the engine, and exposes a read port so the seven-segment display path can show any stored result.

## Interface
- `I_W`, 4, width of engine index `i`; result memory depth is 2^I_W.
- `F_W`, 4, width of engine result `f`.
- `TIMEOUT`, 1023, max cycles to wait for `done_tick` per request (≥1).
- Clocking, decided: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `go`  in  1  one-cycle request to begin a sweep.
- `n_last`  in  I_W  last index to issue; sampled on accepted `go`.
- `start`  out  1  one-cycle request to engine.
- `i`  out  I_W  index presented to engine.
- `done_tick`  in  1  engine completion pulse.
- `f`  in  F_W  engine result, valid while `done_tick`=1.
- `busy`  out  1  sweep in progress.
- `sweep_done_tick`  out  1  one-cycle pulse when sweep ends (normal or error).
- `err`  out  1  sticky timeout flag; cleared by reset or next accepted `go`.
- `rd_addr`  in  I_W  result read address.
- `rd_data`  out  F_W  combinational read of result memory.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: `go`=1 latches `n_last` into `last_r`, clears `i`, clears `err` -> ISSUE. `go` in any other state is ignored.
- ISSUE: `start`=1 for this cycle only; the timeout counter is cleared -> WAIT. A `done_tick` arriving in ISSUE is ignored.
- WAIT: `done_tick`=1 writes `f` to `mem[i]`.
  - If `i`==`last_r` -> DONE.
  - Otherwise `i`++ -> ISSUE.
- WAIT: with no `done_tick`, the counter increments. When it reaches `TIMEOUT`, set `err`=1 and go to DONE. Memory is not written for that index.
- Simultaneous `done_tick` and timeout expiry: `done_tick` wins; no error.
- DONE: `sweep_done_tick`=1 for one cycle -> IDLE. `i` holds its final value.
- `done_tick` in IDLE or DONE is ignored.
- `n_last`=0 gives a single request. `n_last`=2^I_W−1 fills the whole memory. `i` never wraps, because the compare happens before the increment.
- Result memory is not cleared by reset. Entries not written in the current sweep keep their old values.
- Reset mid-sweep aborts immediately: state IDLE, no further `start`. The memory keeps whatever was written before the reset.

## Timing
- Reset values: `start`=0, `i`=0, `busy`=0, `sweep_done_tick`=0, `err`=0, state IDLE, counter 0.
- First `start` is 1 cycle after the accepted `go`.
- `i` is stable from the `start` cycle until the matching `done_tick`.
- Next `start` is 1 cycle after a `done_tick` (minimum 2-cycle issue period per index).
- `sweep_done_tick` is 1 cycle after the final `done_tick` or after the timeout.
- `busy` is 1 in ISSUE, WAIT and DONE.
- Memory write is synchronous on the `done_tick` cycle. `rd_data` reflects the new value the next cycle.

## Structure
- `babbage_pkg`: FSM state encoding (IDLE/ISSUE/WAIT/DONE) and default width constants `I_W`/`F_W`; shared with the engine.
- Sub-module `babbage_result_ram`: 2^I_W × F_W, one synchronous write port and one asynchronous read port.
- FSM, index register and timeout counter live in `babbage_sweep`.

## Test plan
The bench engine model answers with `f`=(2n²+3n+5) mod 16, `done_tick` n+2 cycles after `start`.
- `go` with `n_last`=3 -> exactly 4 `start` pulses with `i`=0,1,2,3. mem = 5,10,3,0. One `sweep_done_tick`; `err`=0.
- `go` with `n_last`=0 -> one `start`, mem[0]=5, `sweep_done_tick` 3 cycles after `start`.
- Model never responds for `i`=2, `TIMEOUT`=15 -> `err`=1 and `sweep_done_tick` 16 cycles after that `start`. mem[2] unchanged; no `start` for `i`=3.
- `done_tick` asserted on exactly cycle `TIMEOUT` -> accepted; `err`=0; sweep continues.
- `go` pulsed again mid-sweep -> ignored, same `start` count. A spurious `done_tick` in IDLE -> no memory write.
- `reset` during WAIT of `i`=5 (`n_last`=15) -> all outputs at reset values next cycle. No further `start`. mem[0..4] intact.
